// File: rtl/qea_engine.sv
`default_nettype none
// ============================================================================
// Module   : qea_engine
// Brief    : Quantum-circuit emulation engine. Applies a gate program held in
//            a context RAM, in place, to a complex state vector spread across
//            PE_NUM lane memories.
// Revision : 1.0  initial release
// ============================================================================
module qea_engine #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
    parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
    parameter int GATE_ADDR_WIDTH         = 6,
    parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 i_ctx_en,
    input  logic                                 i_ctx_wea,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic                                 i_state_ena,
    input  logic                                 i_state_wea,
    input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
    output logic                                 o_complete,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);

    // Width of a full amplitude index (address bits plus lane bits).
    localparam int c_K_W       = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int c_DEPTH     = 1 << STATE_ADDR_WIDTH;
    localparam int c_CTX_DEPTH = 1 << GATE_CONTEXT_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ITER  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Sub-steps of one pair: read a, read b (capture a), capture b, write a', write b'.
    typedef enum logic [2:0] {
        P_RA = 3'd0,
        P_RB = 3'd1,
        P_CB = 3'd2,
        P_WA = 3'd3,
        P_WB = 3'd4
    } phase_t;

    state_t r_state, w_nxt;
    phase_t r_phase;

    logic [2:0]                           r_fcnt;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_pc;
    logic [1:0]                           r_op;
    logic [MAX_QBIT_WIDTH-1:0]            r_ctl;
    logic [MAX_QBIT_WIDTH-1:0]            r_tgt;
    logic [GATE_DATA_WIDTH-1:0]           r_coef [0:3];
    logic [c_K_W-1:0]                     r_j;
    logic [STATE_DATA_WIDTH-1:0]          r_a;
    logic [STATE_DATA_WIDTH-1:0]          r_b;
    logic                                 r_complete;

    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   r_ctx_mem [0:c_CTX_DEPTH-1];
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   r_ctx_rd;

    logic [STATE_DATA_WIDTH-1:0]          w_rd [0:PE_NUM-1];

    // Fixed-point real multiply: full signed product, arithmetic shift, truncate.
    function automatic logic [ALU_DATA_WIDTH-1:0] f_fmul(input logic [ALU_DATA_WIDTH-1:0] x,
                                                         input logic [ALU_DATA_WIDTH-1:0] y);
        logic signed [2*ALU_DATA_WIDTH-1:0] xs;
        logic signed [2*ALU_DATA_WIDTH-1:0] ys;
        logic signed [2*ALU_DATA_WIDTH-1:0] p;
        xs = signed'({{ALU_DATA_WIDTH{x[ALU_DATA_WIDTH-1]}}, x});
        ys = signed'({{ALU_DATA_WIDTH{y[ALU_DATA_WIDTH-1]}}, y});
        p  = (xs * ys) >>> NUM_FRAC_BIT;
        return p[ALU_DATA_WIDTH-1:0];
    endfunction

    function automatic logic [STATE_DATA_WIDTH-1:0] f_cmul(input logic [STATE_DATA_WIDTH-1:0] u,
                                                           input logic [STATE_DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
        re = f_fmul(u[2*DATA_WIDTH-1:DATA_WIDTH], v[2*DATA_WIDTH-1:DATA_WIDTH])
           - f_fmul(u[DATA_WIDTH-1:0], v[DATA_WIDTH-1:0]);
        im = f_fmul(u[2*DATA_WIDTH-1:DATA_WIDTH], v[DATA_WIDTH-1:0])
           + f_fmul(u[DATA_WIDTH-1:0], v[2*DATA_WIDTH-1:DATA_WIDTH]);
        return {re, im};
    endfunction

    function automatic logic [STATE_DATA_WIDTH-1:0] f_cadd(input logic [STATE_DATA_WIDTH-1:0] x,
                                                           input logic [STATE_DATA_WIDTH-1:0] y);
        return {x[2*DATA_WIDTH-1:DATA_WIDTH] + y[2*DATA_WIDTH-1:DATA_WIDTH],
                x[DATA_WIDTH-1:0] + y[DATA_WIDTH-1:0]};
    endfunction

    // ---------------- combinational helpers ----------------
    logic [1:0]                         w_hdr_op;
    logic                               w_is_gate;
    logic [GATE_ADDR_WIDTH-1:0]         w_cidx;
    logic                               w_coef_cap;
    logic                               w_coef_last;
    logic [c_K_W-1:0]                   w_lo_mask;
    logic [c_K_W-1:0]                   w_ka;
    logic [c_K_W-1:0]                   w_kb;
    logic [c_K_W-1:0]                   w_j_max;
    logic                               w_last;
    logic                               w_ctl_set;
    logic                               w_skip;
    logic                               w_pair_end;
    logic                               w_host_act;
    logic [STATE_ADDR_WIDTH-1:0]        w_eng_addr;
    logic [PE_NUM_WIDTH-1:0]            w_eng_lane;
    logic                               w_eng_we;
    logic [STATE_DATA_WIDTH-1:0]        w_eng_wd;
    logic [STATE_DATA_WIDTH-1:0]        w_a_new;
    logic [STATE_DATA_WIDTH-1:0]        w_b_new;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] w_ctx_raddr;

    assign w_hdr_op    = r_ctx_rd[GATE_CONTEXT_DATA_WIDTH-1 -: 2];
    assign w_is_gate   = (w_hdr_op == 2'b01) || (w_hdr_op == 2'b10);
    assign w_cidx      = GATE_ADDR_WIDTH'(r_fcnt) - GATE_ADDR_WIDTH'(2);
    assign w_coef_cap  = (r_fcnt >= 3'd2);
    assign w_coef_last = w_coef_cap && (w_cidx == GATE_ADDR_WIDTH'(3));
    assign w_ctx_raddr = r_pc + GATE_CONTEXT_ADDR_WIDTH'(r_fcnt);

    // Pair index j expands into k by inserting a 0 at the target bit.
    assign w_lo_mask  = (c_K_W'(1) << r_tgt) - c_K_W'(1);
    assign w_ka       = ((r_j & ~w_lo_mask) << 1) | (r_j & w_lo_mask);
    assign w_kb       = w_ka | (c_K_W'(1) << r_tgt);
    assign w_j_max    = (c_K_W'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(1))) - c_K_W'(1);
    assign w_last     = (r_j == w_j_max);
    assign w_ctl_set  = |(w_ka & (c_K_W'(1) << r_ctl));
    assign w_skip     = (r_op == 2'b10) && !w_ctl_set;
    assign w_pair_end = (r_phase == P_WB) || ((r_phase == P_RA) && w_skip);

    assign w_host_act = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_state_ena;

    assign w_a_new = f_cadd(f_cmul(r_coef[0], r_a), f_cmul(r_coef[1], r_b));
    assign w_b_new = f_cadd(f_cmul(r_coef[2], r_a), f_cmul(r_coef[3], r_b));

    // Engine-side state RAM access, selected by pair sub-step.
    always_comb begin
        w_eng_addr = w_kb[c_K_W-1:PE_NUM_WIDTH];
        w_eng_lane = w_kb[PE_NUM_WIDTH-1:0];
        w_eng_we   = 1'b0;
        w_eng_wd   = w_b_new;
        if ((r_phase == P_RA) || (r_phase == P_WA)) begin
            w_eng_addr = w_ka[c_K_W-1:PE_NUM_WIDTH];
            w_eng_lane = w_ka[PE_NUM_WIDTH-1:0];
            w_eng_wd   = w_a_new;
        end
        if ((r_state == S_ITER) && ((r_phase == P_WA) || (r_phase == P_WB))) begin
            w_eng_we = 1'b1;
        end
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_nxt = S_FETCH;
            S_FETCH: begin
                if ((r_fcnt == 3'd1) && !w_is_gate) w_nxt = S_DONE;
                else if (w_coef_last)               w_nxt = S_ITER;
            end
            S_ITER:  if (w_pair_end && w_last) w_nxt = S_NEXT;
            S_NEXT:  w_nxt = S_FETCH;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Sequencing registers: fetch counter, program counter, gate fields, pair walk.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_fcnt     <= '0;
            r_pc       <= '0;
            r_op       <= '0;
            r_ctl      <= '0;
            r_tgt      <= '0;
            r_j        <= '0;
            r_phase    <= P_RA;
            r_a        <= '0;
            r_b        <= '0;
            r_complete <= 1'b0;
            for (int i = 0; i < 4; i++) r_coef[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_complete <= 1'b0;
                        r_pc       <= '0;
                        r_fcnt     <= '0;
                    end
                end
                S_FETCH: begin
                    r_fcnt <= r_fcnt + 3'd1;
                    if (r_fcnt == 3'd1) begin
                        r_op  <= w_hdr_op;
                        r_ctl <= r_ctx_rd[8 +: MAX_QBIT_WIDTH];
                        r_tgt <= r_ctx_rd[0 +: MAX_QBIT_WIDTH];
                        if (!w_is_gate) r_complete <= 1'b1;
                    end
                    if (w_coef_cap) r_coef[w_cidx[1:0]] <= r_ctx_rd;
                    if (w_coef_last) begin
                        r_j     <= '0;
                        r_phase <= P_RA;
                    end
                end
                S_ITER: begin
                    case (r_phase)
                        P_RA: begin
                            if (w_skip) r_j <= r_j + c_K_W'(1);
                            else        r_phase <= P_RB;
                        end
                        P_RB: begin
                            r_a     <= w_rd[w_ka[PE_NUM_WIDTH-1:0]];
                            r_phase <= P_CB;
                        end
                        P_CB: begin
                            r_b     <= w_rd[w_kb[PE_NUM_WIDTH-1:0]];
                            r_phase <= P_WA;
                        end
                        P_WA: r_phase <= P_WB;
                        default: begin
                            r_j     <= r_j + c_K_W'(1);
                            r_phase <= P_RA;
                        end
                    endcase
                end
                S_NEXT: begin
                    r_pc   <= r_pc + GATE_CONTEXT_ADDR_WIDTH'(5);
                    r_fcnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_complete = r_complete;

    // Context RAM: host write port, engine synchronous read port.
    always_ff @(posedge clk) begin
        if (i_ctx_en && i_ctx_wea) r_ctx_mem[i_ctx_addr] <= i_ctx_data;
        r_ctx_rd <= r_ctx_mem[w_ctx_raddr];
    end

    // ---------------- lane memories ----------------
    for (genvar p = 0; p < PE_NUM; p++) begin : g_lane
        logic [STATE_DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
        logic [STATE_DATA_WIDTH-1:0] r_rd_l;
        logic [STATE_DATA_WIDTH-1:0] r_dout_l;
        logic [STATE_ADDR_WIDTH-1:0] w_addr;
        logic                        w_we;
        logic [STATE_DATA_WIDTH-1:0] w_wd;

        assign w_addr = w_host_act ? i_state_addra : w_eng_addr;
        assign w_we   = w_host_act ? i_state_wea
                                   : (w_eng_we && (w_eng_lane == PE_NUM_WIDTH'(p)));
        assign w_wd   = w_host_act ? i_state_dina[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH]
                                   : w_eng_wd;

        // Read-first single port shared by host and engine.
        always_ff @(posedge clk) begin
            r_rd_l <= r_mem[w_addr];
            if (w_we) r_mem[w_addr] <= w_wd;
        end

        // Host read register: only updates on an honoured host access.
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n)           r_dout_l <= '0;
            else if (w_host_act) r_dout_l <= r_mem[w_addr];
        end

        assign w_rd[p] = r_rd_l;
        assign o_state_dout[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] = r_dout_l;
    end

endmodule
`default_nettype wire

// File: tb/tb_qea_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_qea_engine
// Brief    : Scoreboard bench for qea_engine: directed gate programs, host
//            read-back compared against hand-computed amplitudes.
// Revision : 1.0  initial release
// ============================================================================
module tb_qea_engine;

    localparam logic [63:0] c_ONE  = 64'h40000000_00000000;
    localparam logic [63:0] c_H    = 64'h2D413CCC_00000000;
    localparam logic [63:0] c_HN   = 64'hD2BEC334_00000000;
    localparam logic [63:0] c_ZERO = 64'h0;
    localparam int          c_NADDR = 256;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [5:0]   i_qbit_num;
    logic         i_ctx_en;
    logic         i_ctx_wea;
    logic [15:0]  i_ctx_addr;
    logic [63:0]  i_ctx_data;
    logic         i_state_ena;
    logic         i_state_wea;
    logic [15:0]  i_state_addra;
    logic [255:0] i_state_dina;
    logic         o_complete;
    logic [255:0] o_state_dout;

    qea_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_qbit_num    (i_qbit_num),
        .i_ctx_en      (i_ctx_en),
        .i_ctx_wea     (i_ctx_wea),
        .i_ctx_addr    (i_ctx_addr),
        .i_ctx_data    (i_ctx_data),
        .i_state_ena   (i_state_ena),
        .i_state_wea   (i_state_wea),
        .i_state_addra (i_state_addra),
        .i_state_dina  (i_state_dina),
        .o_complete    (o_complete),
        .o_state_dout  (o_state_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] v;
        int           addr;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        tb_rd_vld = 1'b0;
    int          tb_rd_addr = 0;
    logic [63:0] init_amp [0:1023];
    logic [63:0] exp_amp  [0:1023];

    // Note which host reads the DUT should answer on the next cycle.
    always @(posedge clk) begin
        tb_rd_vld  <= i_state_ena && !rst_n;
        tb_rd_addr <= int'(i_state_addra);
    end

    // Monitor: pop the scoreboard for every answered host read.
    always @(negedge clk) begin
        if (tb_rd_vld) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty addr=%0d got=%h", tb_rd_addr, o_state_dout);
            end else begin
                e = sb_q.pop_front();
                if (o_state_dout !== e.v) begin
                    failures++;
                    $display("FAIL state_rd addr=%0d got=%h exp=%h", e.addr, o_state_dout, e.v);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [255:0] pack_init(input int a);
        logic [255:0] w;
        for (int p = 0; p < 4; p++) w[(4-p)*64-1 -: 64] = init_amp[a*4+p];
        return w;
    endfunction

    function automatic logic [255:0] pack_exp(input int a);
        logic [255:0] w;
        for (int p = 0; p < 4; p++) w[(4-p)*64-1 -: 64] = exp_amp[a*4+p];
        return w;
    endfunction

    function automatic logic [63:0] hdr(input logic [1:0] op, input logic [5:0] c, input logic [5:0] t);
        logic [63:0] h;
        h        = '0;
        h[63:62] = op;
        h[13:8]  = c;
        h[5:0]   = t;
        return h;
    endfunction

    task automatic clear_amps();
        for (int i = 0; i < 1024; i++) begin
            init_amp[i] = c_ZERO;
            exp_amp[i]  = c_ZERO;
        end
    endtask

    task automatic ctx_wr(input int a, input logic [63:0] d);
        i_ctx_en   = 1'b1;
        i_ctx_wea  = 1'b1;
        i_ctx_addr = 16'(a);
        i_ctx_data = d;
        tick();
        i_ctx_en   = 1'b0;
        i_ctx_wea  = 1'b0;
    endtask

    task automatic gate_wr(input int base, input logic [63:0] h, input logic [63:0] u00,
                           input logic [63:0] u01, input logic [63:0] u10, input logic [63:0] u11);
        ctx_wr(base,     h);
        ctx_wr(base + 1, u00);
        ctx_wr(base + 2, u01);
        ctx_wr(base + 3, u10);
        ctx_wr(base + 4, u11);
    endtask

    task automatic load_state();
        for (int a = 0; a < c_NADDR; a++) begin
            i_state_ena   = 1'b1;
            i_state_wea   = 1'b1;
            i_state_addra = 16'(a);
            i_state_dina  = pack_init(a);
            sb_q.push_back('{v: 256'(0), addr: a});
            tick();
        end
        i_state_ena = 1'b0;
        i_state_wea = 1'b0;
        tick();
        tick();
    endtask

    // The load pass above also reads; clear its expectations before it runs.
    task automatic load_state_clean();
        int n0;
        n0 = sb_q.size();
        for (int a = 0; a < c_NADDR; a++) begin
            i_state_ena   = 1'b1;
            i_state_wea   = 1'b1;
            i_state_addra = 16'(a);
            i_state_dina  = pack_init(a);
            tick();
            // drop the DUT answer of this write cycle from checking
            tb_rd_vld = 1'b0;
        end
        i_state_ena = 1'b0;
        i_state_wea = 1'b0;
        tick();
        tick();
        if (sb_q.size() != n0) sb_q.delete();
    endtask

    task automatic read_check();
        for (int a = 0; a < c_NADDR; a++) begin
            i_state_ena   = 1'b1;
            i_state_wea   = 1'b0;
            i_state_addra = 16'(a);
            sb_q.push_back('{v: pack_exp(a), addr: a});
            tick();
        end
        i_state_ena = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_prog(input string nm, output int cyc);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0;
        while (!o_complete && cyc < 20000) begin
            tick();
            cyc++;
        end
        checks++;
        if (!o_complete) begin
            failures++;
            $display("FAIL %s_complete got=0 exp=1 after %0d cycles", nm, cyc);
        end
    endtask

    int cyc;

    initial begin
        rst_n         = 1'b1;
        i_start       = 1'b0;
        i_qbit_num    = 6'd10;
        i_ctx_en      = 1'b0;
        i_ctx_wea     = 1'b0;
        i_ctx_addr    = '0;
        i_ctx_data    = '0;
        i_state_ena   = 1'b0;
        i_state_wea   = 1'b0;
        i_state_addra = '0;
        i_state_dina  = '0;
        repeat (3) tick();
        chk("reset_complete", 256'(o_complete), 256'(0));
        chk("reset_dout", o_state_dout, 256'(0));
        rst_n = 1'b0;
        tick();

        // H on q0: |0> -> (|0> + |1>)/sqrt2
        clear_amps();
        gate_wr(0, hdr(2'b01, 6'd0, 6'd0), c_H, c_H, c_H, c_HN);
        ctx_wr(5, c_ZERO);
        init_amp[0] = c_ONE;
        load_state_clean();
        run_prog("h_q0", cyc);
        exp_amp[0] = c_H;
        exp_amp[1] = c_H;
        read_check();

        // X on q5: amplitude 0 moves to index 32 (addr 8, lane 0)
        clear_amps();
        gate_wr(0, hdr(2'b01, 6'd0, 6'd5), c_ZERO, c_ONE, c_ONE, c_ZERO);
        ctx_wr(5, c_ZERO);
        init_amp[0] = c_ONE;
        load_state_clean();
        run_prog("x_q5", cyc);
        exp_amp[32] = c_ONE;
        read_check();

        // X(q0) then CU(c=0,t=1) X: |0> -> |1> -> |3>
        clear_amps();
        gate_wr(0, hdr(2'b01, 6'd0, 6'd0), c_ZERO, c_ONE, c_ONE, c_ZERO);
        gate_wr(5, hdr(2'b10, 6'd0, 6'd1), c_ZERO, c_ONE, c_ONE, c_ZERO);
        ctx_wr(10, c_ZERO);
        init_amp[0] = c_ONE;
        load_state_clean();
        run_prog("cx", cyc);
        exp_amp[3] = c_ONE;
        read_check();

        // Empty program: quick completion, state untouched
        ctx_wr(0, c_ZERO);
        run_prog("end_only", cyc);
        checks++;
        if (cyc > 10) begin
            failures++;
            $display("FAIL end_latency got=%0d exp<=10", cyc);
        end
        read_check();

        // Read-first write of zero, then a second read sees zero
        i_state_ena   = 1'b1;
        i_state_wea   = 1'b1;
        i_state_addra = 16'd0;
        i_state_dina  = '0;
        sb_q.push_back('{v: pack_exp(0), addr: 0});
        tick();
        i_state_wea = 1'b0;
        sb_q.push_back('{v: 256'(0), addr: 0});
        tick();
        i_state_ena = 1'b0;
        tick();
        tick();
        exp_amp[3] = c_ZERO;

        // Reset during a run, then rerun from a reloaded state
        clear_amps();
        gate_wr(0, hdr(2'b01, 6'd0, 6'd5), c_ZERO, c_ONE, c_ONE, c_ZERO);
        ctx_wr(5, c_ZERO);
        init_amp[0] = c_ONE;
        load_state_clean();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (200) tick();
        chk("midrun_busy", 256'(o_complete), 256'(0));
        rst_n = 1'b1;
        tick();
        tick();
        chk("midrun_rst_complete", 256'(o_complete), 256'(0));
        chk("midrun_rst_dout", o_state_dout, 256'(0));
        rst_n = 1'b0;
        tick();
        load_state_clean();
        run_prog("after_rst", cyc);
        exp_amp[32] = c_ONE;
        read_check();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qea_engine.md
Name: qea_engine

Overview:
- Quantum-circuit emulation accelerator. Holds a state vector of up to 2^(STATE_ADDR_WIDTH+2) complex amplitudes in PE_NUM parallel lane memories.
- Holds a gate program in a context RAM and applies it to the state vector in place.
- A host loads the program and the initial state, pulses start, waits for complete, then reads the state back through the same host port.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM.
- PE_NUM, 4, number of amplitude lanes per state address.
- DATA_WIDTH, 32, width of one real or imaginary component.
- MAX_QBIT_WIDTH, 6, width of qubit-count and qubit-index fields.
- ALU_DATA_WIDTH, DATA_WIDTH, ALU operand width.
- STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude: {re[63:32], im[31:0]}.
- STATE_ADDR_WIDTH, 16, state RAM address width, per lane.
- GATE_DATA_WIDTH, 2*DATA_WIDTH, one complex gate coefficient.
- GATE_ADDR_WIDTH, 6, index width of the internal coefficient buffer. At least 2 bits are used.
- GATE_CONTEXT_DATA_WIDTH, 2*DATA_WIDTH, context RAM word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width.
- NUM_FRAC_BIT, 30, fractional bits of the signed fixed-point format. 1.0 = 0x40000000.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle pulse to start program execution.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count n. Legal range 2..STATE_ADDR_WIDTH+2. Must be stable while running.
- i_ctx_en  in  1  context RAM port enable.
- i_ctx_wea  in  1  context RAM write enable.
- i_ctx_addr  in  GATE_CONTEXT_ADDR_WIDTH  context word address.
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context write data.
- i_state_ena  in  1  host state-port enable, all lanes.
- i_state_wea  in  1  host state-port write enable, all lanes.
- i_state_addra  in  STATE_ADDR_WIDTH  state address.
- i_state_dina  in  PE_NUM*STATE_DATA_WIDTH  write data. Lane 0 occupies the MS 64 bits; lane p is at bits [(PE_NUM-p)*64-1 -: 64].
- o_complete  out  1  program finished (level).
- o_state_dout  out  PE_NUM*STATE_DATA_WIDTH  host read data, same lane packing as i_state_dina.

Behaviour:
- Amplitude mapping: amplitude index k = addr*PE_NUM + lane. Qubit q is bit q of k. Active addresses are 0..2^(n-2)-1.
- Context RAM: written when i_ctx_en && i_ctx_wea. Contents are zero at configuration.
- Program format: 5-word records starting at context address 0.
  - Word 0 is the header. Words 1..4 are u00, u01, u10, u11, each {re, im}.
  - Header [63:62] is the opcode: 00 = END, 01 = U (single-qubit), 10 = CU (controlled-U), 11 = treated as END.
  - Header [8+MAX_QBIT_WIDTH-1:8] = control qubit. Header [MAX_QBIT_WIDTH-1:0] = target qubit.
- Gate semantics: for every index k with bit t = 0, and, for CU, control bit = 1, with k' = k | (1<<t):
  - a' = u00*a + u01*b; b' = u10*a + u11*b, where a = amp[k], b = amp[k'].
- Arithmetic:
  - Each real product is a signed 64-bit result, arithmetic-shifted right by NUM_FRAC_BIT (truncate), kept to 32 bits.
  - Complex multiply uses re = ar*br - ai*bi and im = ar*bi + ai*br.
  - Sums wrap modulo 2^32. No saturation.
- Pairs are processed serially: read a, read b, compute, write a', b'. The pair may lie in the same address (t < PE_NUM_WIDTH) or in two addresses. Latency is not fixed; the bench must only wait on o_complete.
- FSM states: IDLE, FETCH (header + 4 coefficients), ITER (read/compute/write over pairs), NEXT (address += 5), DONE.
  - i_start in IDLE or DONE: clear o_complete, then go to FETCH at address 0.
  - END opcode: go to DONE and set o_complete = 1. It holds until the next i_start.
  - i_start while busy is ignored.
- Host state port:
  - Honoured only in IDLE/DONE; ignored while running.
  - Read-first: o_state_dout is registered and shows the pre-write contents of i_state_addra one cycle after i_state_ena.
  - Write occurs when i_state_ena && i_state_wea.
  - o_state_dout holds its value when i_state_ena = 0.
- Reset (any time, including mid-run): FSM goes to IDLE; o_complete = 0; o_state_dout = 0. RAM contents are not cleared.

Test Plan:
- n=10, program H(q0) with coefficients 0x2D413CCC, END; state amp[0]=0x40000000_00000000 -> after complete, addr0 lane0 = lane1 = 0x2D413CCC_00000000 (±1 LSB), all else 0.
- n=10, X(q5), END -> addr 8 lane 0 = 0x40000000_00000000; addr 0 = all zero.
- n=10, X(q0) then CU(c=0, t=1) with X matrix, END -> addr0 lane3 = 1.0, all other lanes zero.
- Context address 0 all-zero (END) -> o_complete rises within 10 cycles of start; state unchanged.
- Read back with i_state_wea=1 and dina=0 -> o_state_dout shows the old data next cycle; a second pass reads 0.
- Assert reset mid-run -> o_complete=0 and FSM idle; a new start with a reloaded state completes correctly.
